// File: rtl/ram_writer.sv
// ram_writer: coalesces 16-bit word writes into 128-bit masked MIG write bursts
module ram_writer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [26:0] write_address,
   input  logic [15:0] write_data_in,
   input  logic        write_valid,
   output logic        write_ready,
   input  logic        flush,
   output logic        idle,
   output logic [26:0] ram_address,
   output logic [2:0]  ram_cmd,
   output logic        ram_en,
   input  logic        ram_rdy,
   output logic [63:0] ram_wdf_data,
   output logic [7:0]  ram_wdf_mask,
   output logic        ram_wdf_wren,
   output logic        ram_wdf_end,
   input  logic        ram_wdf_rdy
);
   typedef enum logic [1:0] {FILL, DATA0, DATA1, CMD} state_t;
   state_t       state_q, state_d;
   logic [7:0]   word_valid_q, word_valid_d;
   logic [23:0]  burst_addr_q, burst_addr_d;
   logic [127:0] burst_buf_q, burst_buf_d;
   logic [7:0]   valid_acc;
   logic [7:0]   mask_hi, mask_lo;
   logic         blocked;
   logic         accept;
   assign ram_cmd = 3'b000;
   // byte masks per beat: both bytes of a word are masked when the word was never written
   always_comb begin
      mask_hi = '0;
      mask_lo = '0;
      for (int j = 0; j < 4; j++) begin
         mask_hi[2*j +: 2] = {2{~word_valid_q[j+4]}};
         mask_lo[2*j +: 2] = {2{~word_valid_q[j]}};
      end
   end
   // next state, buffer update and MIG-side outputs
   always_comb begin
      state_d      = state_q;
      word_valid_d = word_valid_q;
      burst_addr_d = burst_addr_q;
      burst_buf_d  = burst_buf_q;
      valid_acc    = word_valid_q;
      blocked      = |word_valid_q && (write_address[26:3] != burst_addr_q);
      accept       = 1'b0;
      write_ready  = 1'b0;
      idle         = 1'b0;
      ram_en       = 1'b0;
      ram_address  = '0;
      ram_wdf_wren = 1'b0;
      ram_wdf_end  = 1'b0;
      ram_wdf_data = '0;
      ram_wdf_mask = '0;
      case (state_q)
         FILL: begin
            write_ready = reset_n && !blocked;
            idle        = word_valid_q == 8'h00;
            accept      = write_valid && write_ready;
            if (accept) begin
               burst_buf_d[{write_address[2:0], 4'b0000} +: 16] = write_data_in;
               valid_acc    = word_valid_q | (8'd1 << write_address[2:0]);
               burst_addr_d = write_address[26:3];
            end
            word_valid_d = valid_acc;
            if (valid_acc == 8'hFF || (flush && |valid_acc) || (write_valid && blocked))
               state_d = DATA0;
         end
         DATA0: begin
            ram_wdf_wren = 1'b1;
            ram_wdf_data = burst_buf_q[127:64];
            ram_wdf_mask = mask_hi;
            if (ram_wdf_rdy) state_d = DATA1;
         end
         DATA1: begin
            ram_wdf_wren = 1'b1;
            ram_wdf_end  = 1'b1;
            ram_wdf_data = burst_buf_q[63:0];
            ram_wdf_mask = mask_lo;
            if (ram_wdf_rdy) state_d = CMD;
         end
         CMD: begin
            ram_en      = 1'b1;
            ram_address = {burst_addr_q, 3'b000};
            if (ram_rdy) begin
               word_valid_d = '0;
               state_d      = FILL;
            end
         end
      endcase
   end
   // state registers; reset abandons any burst in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= FILL;
         word_valid_q <= '0;
         burst_addr_q <= '0;
         burst_buf_q  <= '0;
      end else begin
         state_q      <= state_d;
         word_valid_q <= word_valid_d;
         burst_addr_q <= burst_addr_d;
         burst_buf_q  <= burst_buf_d;
      end
   end
endmodule

// File: tb/tb_ram_writer.sv
// tb_ram_writer: directed stimulus with a burst-level reference model checked every cycle
module tb_ram_writer;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [26:0] write_address = '0;
   logic [15:0] write_data_in = '0;
   logic        write_valid = 1'b0;
   logic        write_ready;
   logic        flush = 1'b0;
   logic        idle;
   logic [26:0] ram_address;
   logic [2:0]  ram_cmd;
   logic        ram_en;
   logic        ram_rdy = 1'b1;
   logic [63:0] ram_wdf_data;
   logic [7:0]  ram_wdf_mask;
   logic        ram_wdf_wren;
   logic        ram_wdf_end;
   logic        ram_wdf_rdy = 1'b1;

   ram_writer dut (
      .clk(clk), .reset_n(reset_n), .write_address(write_address),
      .write_data_in(write_data_in), .write_valid(write_valid), .write_ready(write_ready),
      .flush(flush), .idle(idle), .ram_address(ram_address), .ram_cmd(ram_cmd),
      .ram_en(ram_en), .ram_rdy(ram_rdy), .ram_wdf_data(ram_wdf_data),
      .ram_wdf_mask(ram_wdf_mask), .ram_wdf_wren(ram_wdf_wren), .ram_wdf_end(ram_wdf_end),
      .ram_wdf_rdy(ram_wdf_rdy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model: words held per slot, which slots are written, burst base, write-out phase
   logic [15:0] m_words [8];
   bit          m_valid [8];
   logic [23:0] m_base = '0;
   int          m_phase = 0;

   // records of what the DUT handed to the controller
   int          n_beats = 0;
   int          n_cmds = 0;
   logic [63:0] b0_data, b1_data;
   logic [7:0]  b0_mask, b1_mask;
   logic [26:0] cmd_addr;
   logic        hold_w = 1'b0, hold_c = 1'b0;
   logic [63:0] prev_data;
   logic [7:0]  prev_mask;
   logic        prev_end;
   logic [26:0] prev_addr;

   initial for (int i = 0; i < 8; i++) m_words[i] = '0;

   always @(negedge clk) begin : cmp
      int cnt, idx, off;
      logic blk, er, ei, een, ewr, eend;
      logic [26:0] ea;
      logic [63:0] ed, keep;
      logic [7:0] em;
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
         m_base = '0;
         m_phase = 0;
      end
      cnt = 0;
      for (int i = 0; i < 8; i++) cnt += int'(m_valid[i]);
      blk  = cnt > 0 && write_address[26:3] != m_base;
      er   = reset_n && m_phase == 0 && !blk;
      ei   = m_phase == 0 && cnt == 0;
      ewr  = m_phase == 1 || m_phase == 2;
      eend = m_phase == 2;
      een  = m_phase == 3;
      ea   = een ? {m_base, 3'b000} : 27'd0;
      off  = m_phase == 1 ? 4 : 0;
      ed = '0;
      em = '0;
      keep = '0;
      if (ewr) begin
         for (int w = 0; w < 4; w++) ed[16*w +: 16] = m_words[w+off];
         for (int b = 0; b < 8; b++) em[b] = !m_valid[b/2+off];
      end
      for (int b = 0; b < 8; b++) keep[8*b +: 8] = em[b] ? 8'h00 : 8'hFF;
      chk("write_ready", 64'(write_ready), 64'(er));
      chk("idle", 64'(idle), 64'(ei));
      chk("ram_en", 64'(ram_en), 64'(een));
      chk("ram_address", 64'(ram_address), 64'(ea));
      chk("ram_cmd", 64'(ram_cmd), 64'd0);
      chk("wdf_wren", 64'(ram_wdf_wren), 64'(ewr));
      chk("wdf_end", 64'(ram_wdf_end), 64'(eend));
      chk("wdf_mask", 64'(ram_wdf_mask), 64'(em));
      chk("wdf_data", ram_wdf_data & keep, ed & keep);
      if (hold_w && reset_n) begin
         chk("hold_data", ram_wdf_data, prev_data);
         chk("hold_mask", 64'(ram_wdf_mask), 64'(prev_mask));
         chk("hold_end", 64'(ram_wdf_end), 64'(prev_end));
      end
      if (hold_c && reset_n) chk("hold_addr", 64'(ram_address), 64'(prev_addr));
      hold_w = reset_n && ram_wdf_wren && !ram_wdf_rdy;
      hold_c = reset_n && ram_en && !ram_rdy;
      prev_data = ram_wdf_data;
      prev_mask = ram_wdf_mask;
      prev_end  = ram_wdf_end;
      prev_addr = ram_address;
      if (reset_n && ram_wdf_wren && ram_wdf_rdy) begin
         n_beats++;
         if (ram_wdf_end) begin b1_data = ram_wdf_data; b1_mask = ram_wdf_mask; end
         else begin b0_data = ram_wdf_data; b0_mask = ram_wdf_mask; end
      end
      if (reset_n && ram_en && ram_rdy) begin
         n_cmds++;
         cmd_addr = ram_address;
      end
      if (reset_n) begin
         if (m_phase == 0) begin
            if (write_valid && !blk) begin
               idx = int'(write_address[2:0]);
               if (!m_valid[idx]) cnt++;
               m_words[idx] = write_data_in;
               m_valid[idx] = 1'b1;
               m_base = write_address[26:3];
            end
            if (cnt == 8 || (flush && cnt > 0) || (write_valid && blk)) m_phase = 1;
         end else if (m_phase == 1 || m_phase == 2) begin
            if (ram_wdf_rdy) m_phase++;
         end else if (ram_rdy) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
            m_phase = 0;
         end
      end
   end

   task automatic wr(input logic [26:0] a, input logic [15:0] d);
      logic got;
      got = 1'b0;
      write_valid = 1'b1;
      write_address = a;
      write_data_in = d;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (write_ready) begin got = 1'b1; break; end
      end
      chk("accept_timeout", 64'(got), 64'd1);
      @(posedge clk);
      #1 write_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n++;
         if (idle) break;
      end
      chk("idle_timeout", 64'(idle), 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, bc, cc;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", 64'(write_ready), 64'd0);
      chk("reset_idle", 64'(idle), 64'd1);
      reset_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 64'(write_ready), 64'd1);
      @(posedge clk);
      #1;
      // sequential fill of burst 0x40
      for (int i = 0; i < 8; i++) wr(27'h40 + 27'(i), 16'h1000 + 16'(i));
      wait_idle(n);
      chk("fill_latency", 64'(n), 64'd4);
      chk("fill_b0_data", b0_data, 64'h1007_1006_1005_1004);
      chk("fill_b0_mask", 64'(b0_mask), 64'h00);
      chk("fill_b1_data", b1_data, 64'h1003_1002_1001_1000);
      chk("fill_b1_mask", 64'(b1_mask), 64'h00);
      chk("fill_cmd_addr", 64'(cmd_addr), 64'h40);
      chk("fill_cmds", 64'(n_cmds), 64'd1);
      // partial flush of one word
      wr(27'h85, 16'hBEEF);
      pulse_flush();
      wait_idle(n);
      chk("part_b0_mask", 64'(b0_mask), 64'hF3);
      chk("part_b0_word", 64'(b0_data[31:16]), 64'hBEEF);
      chk("part_b1_mask", 64'(b1_mask), 64'hFF);
      chk("part_cmd_addr", 64'(cmd_addr), 64'h80);
      // eviction on a miss
      cc = n_cmds;
      wr(27'h10, 16'hAAAA);
      wr(27'h20, 16'hBBBB);
      chk("evict_cmds", 64'(n_cmds - cc), 64'd1);
      chk("evict_cmd_addr", 64'(cmd_addr), 64'h10);
      chk("evict_b1_mask", 64'(b1_mask), 64'hFC);
      chk("evict_b1_word", 64'(b1_data[15:0]), 64'hAAAA);
      pulse_flush();
      wait_idle(n);
      chk("evict2_cmd_addr", 64'(cmd_addr), 64'h20);
      chk("evict2_b1_word", 64'(b1_data[15:0]), 64'hBBBB);
      // overwrite of the same word
      cc = n_cmds;
      wr(27'h3, 16'h1111);
      wr(27'h3, 16'h2222);
      pulse_flush();
      wait_idle(n);
      chk("ovw_cmds", 64'(n_cmds - cc), 64'd1);
      chk("ovw_b1_word", 64'(b1_data[63:48]), 64'h2222);
      chk("ovw_b1_mask", 64'(b1_mask), 64'h3F);
      chk("ovw_cmd_addr", 64'(cmd_addr), 64'h0);
      // backpressure on data beats then on the command
      bc = n_beats;
      cc = n_cmds;
      ram_wdf_rdy = 1'b0;
      ram_rdy = 1'b0;
      wr(27'h106, 16'h5555);
      pulse_flush();
      repeat (5) @(posedge clk);
      #1 ram_wdf_rdy = 1'b1;
      repeat (2) @(posedge clk);
      repeat (4) @(posedge clk);
      #1 ram_rdy = 1'b1;
      wait_idle(n);
      chk("bp_beats", 64'(n_beats - bc), 64'd2);
      chk("bp_cmds", 64'(n_cmds - cc), 64'd1);
      chk("bp_b0_mask", 64'(b0_mask), 64'hCF);
      chk("bp_b0_word", 64'(b0_data[47:32]), 64'h5555);
      chk("bp_cmd_addr", 64'(cmd_addr), 64'h100);
      // asynchronous reset while beat 1 is presented
      wr(27'h200, 16'h7777);
      pulse_flush();
      @(posedge clk);
      #2;
      chk("pre_reset_end", 64'(ram_wdf_end), 64'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("arst_wren", 64'(ram_wdf_wren), 64'd0);
      chk("arst_end", 64'(ram_wdf_end), 64'd0);
      chk("arst_data", ram_wdf_data, 64'd0);
      chk("arst_mask", 64'(ram_wdf_mask), 64'd0);
      chk("arst_idle", 64'(idle), 64'd1);
      chk("arst_ready", 64'(write_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("post_arst_ready", 64'(write_ready), 64'd1);
      chk("post_arst_idle", 64'(idle), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
